// File: rtl/pad_input_conditioner.sv
// pad_input_conditioner
//    Input-side conditioning for one padring side. Each pad bit is gated by its
//    input enable, synchronized into clk_i, glitch-filtered with a programmable
//    stable-count, and produces single-cycle rise/fall event pulses.
//
//    Optional feature macro: PADIN_EVT_IRQ_EN
//       defined   : sticky per-bit event pending flags with write-1-to-clear and
//                   a registered, masked interrupt output
//       undefined : evt_pending_o and irq_o are tied to 0; evt_mask_i and
//                   evt_clr_i are ignored (ports kept for identical instantiation)
//
//    Ports
//       clk_i          clock
//       rst_ni         synchronous active-low reset
//       pad_din_i      raw asynchronous pad data
//       ie_i           per-pad input enable (0 forces the sampled bit to 0)
//       filt_cycles_i  stable-count threshold N; N+1 differing samples flip din_o
//       din_o          filtered, synchronized level
//       rise_o/fall_o  1-cycle pulses coincident with the first cycle of a new din_o
//       evt_mask_i     per-bit interrupt enable
//       evt_clr_i      write-1-to-clear for pending flags
//       evt_pending_o  sticky event flags
//       irq_o          registered OR of pending & mask
module pad_input_conditioner #(
   parameter int WIDTH       = 9,
   parameter int SYNC_STAGES = 2,
   parameter int FILT_W      = 4
) (
   input  logic              clk_i,
   input  logic              rst_ni,
   input  logic [WIDTH-1:0]  pad_din_i,
   input  logic [WIDTH-1:0]  ie_i,
   input  logic [FILT_W-1:0] filt_cycles_i,
   output logic [WIDTH-1:0]  din_o,
   output logic [WIDTH-1:0]  rise_o,
   output logic [WIDTH-1:0]  fall_o,
   input  logic [WIDTH-1:0]  evt_mask_i,
   input  logic [WIDTH-1:0]  evt_clr_i,
   output logic [WIDTH-1:0]  evt_pending_o,
   output logic              irq_o
);

   // Synchronizer chain; gating by ie happens before the first flop so a
   // disabled pad looks exactly like a pad driven low.
   logic [WIDTH-1:0] sync_q [SYNC_STAGES];
   logic [WIDTH-1:0] sy;

   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         for (int k = 0; k < SYNC_STAGES; k++) begin
            sync_q[k] <= '0;
         end
      end else begin
         sync_q[0] <= pad_din_i & ie_i;
         for (int k = 1; k < SYNC_STAGES; k++) begin
            sync_q[k] <= sync_q[k-1];
         end
      end
   end

   assign sy = sync_q[SYNC_STAGES-1];

   // Per-bit stable-count filter.
   logic [FILT_W-1:0] cnt_q [WIDTH];
   logic [FILT_W-1:0] cnt_d [WIDTH];
   logic [WIDTH-1:0]  din_q, din_d;
   logic [WIDTH-1:0]  rise_q, rise_d;
   logic [WIDTH-1:0]  fall_q, fall_d;

   always_comb begin
      din_d  = din_q;
      rise_d = '0;
      fall_d = '0;
      for (int i = 0; i < WIDTH; i++) begin
         cnt_d[i] = cnt_q[i];
         if (sy[i] == din_q[i]) begin
            cnt_d[i] = '0;
         end else if (cnt_q[i] < filt_cycles_i) begin
            cnt_d[i] = cnt_q[i] + FILT_W'(1);
         end else begin
            // ">=" rather than "==" so a threshold lowered below the running
            // count takes effect immediately instead of letting cnt wrap.
            din_d[i]  = sy[i];
            cnt_d[i]  = '0;
            rise_d[i] = sy[i];
            fall_d[i] = ~sy[i];
         end
      end
   end

   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         din_q  <= '0;
         rise_q <= '0;
         fall_q <= '0;
         for (int i = 0; i < WIDTH; i++) begin
            cnt_q[i] <= '0;
         end
      end else begin
         din_q  <= din_d;
         rise_q <= rise_d;
         fall_q <= fall_d;
         for (int i = 0; i < WIDTH; i++) begin
            cnt_q[i] <= cnt_d[i];
         end
      end
   end

   assign din_o  = din_q;
   assign rise_o = rise_q;
   assign fall_o = fall_q;

`ifdef PADIN_EVT_IRQ_EN
   logic [WIDTH-1:0] pend_q, pend_d;
   logic             irq_q, irq_d;

   // Set wins over clear so an event landing on the clear cycle is not lost.
   always_comb begin
      pend_d = (pend_q & ~evt_clr_i) | rise_q | fall_q;
      irq_d  = |(pend_q & evt_mask_i);
   end

   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         pend_q <= '0;
         irq_q  <= 1'b0;
      end else begin
         pend_q <= pend_d;
         irq_q  <= irq_d;
      end
   end

   assign evt_pending_o = pend_q;
   assign irq_o         = irq_q;
`else
   logic unused_evt_inputs;
   assign unused_evt_inputs = ^{evt_mask_i, evt_clr_i};
   assign evt_pending_o     = '0;
   assign irq_o             = 1'b0;
`endif

endmodule

// File: tb/tb_pad_input_conditioner.sv
module tb_pad_input_conditioner;
   localparam int W  = 9;
   localparam int SS = 2;
   localparam int FW = 4;

   logic          clk = 1'b0;
   logic          rst_n;
   logic [W-1:0]  pad, ie, mask, clr;
   logic [FW-1:0] n;
   logic [W-1:0]  din_o, rise_o, fall_o, pend_o;
   logic          irq_o;

   int n_cmp = 0;
   int n_bad = 0;

   always #5 clk = ~clk;

   pad_input_conditioner #(.WIDTH(W), .SYNC_STAGES(SS), .FILT_W(FW)) dut (
      .clk_i         (clk),
      .rst_ni        (rst_n),
      .pad_din_i     (pad),
      .ie_i          (ie),
      .filt_cycles_i (n),
      .din_o         (din_o),
      .rise_o        (rise_o),
      .fall_o        (fall_o),
      .evt_mask_i    (mask),
      .evt_clr_i     (clr),
      .evt_pending_o (pend_o),
      .irq_o         (irq_o)
   );

   // Behavioural reference: a pure delay line for synchronization, and a
   // run length of consecutive differing samples for the filter.
   logic [W-1:0] dq [$];
   int           run_m [W];
   logic [W-1:0] din_m, rise_m, fall_m, pend_m;
   logic         irq_m;

   task automatic model_edge();
      logic [W-1:0] s, sy;
      s = pad & ie;
      if (!rst_n) begin
         dq.delete();
         for (int k = 0; k < SS; k++) dq.push_back('0);
         for (int i = 0; i < W; i++) run_m[i] = 0;
         din_m = '0; rise_m = '0; fall_m = '0; pend_m = '0; irq_m = 1'b0;
      end else begin
         sy = dq.pop_front();
         dq.push_back(s);
`ifdef PADIN_EVT_IRQ_EN
         irq_m  = |(pend_m & mask);
         pend_m = (pend_m & ~clr) | rise_m | fall_m;
`endif
         rise_m = '0;
         fall_m = '0;
         for (int i = 0; i < W; i++) begin
            if (sy[i] != din_m[i]) begin
               run_m[i] = run_m[i] + 1;
               if (run_m[i] >= int'(n) + 1) begin
                  din_m[i] = sy[i];
                  run_m[i] = 0;
                  if (sy[i]) rise_m[i] = 1'b1;
                  else       fall_m[i] = 1'b1;
               end
            end else begin
               run_m[i] = 0;
            end
         end
      end
   endtask

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s @%0t: got %h expected %h", name, $time, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      model_edge();
      #1;
      chk("model_din",  32'(din_o),  32'(din_m));
      chk("model_rise", 32'(rise_o), 32'(rise_m));
      chk("model_fall", 32'(fall_o), 32'(fall_m));
      chk("model_pend", 32'(pend_o), 32'(pend_m));
      chk("model_irq",  32'(irq_o),  32'(irq_m));
   endtask

   task automatic do_reset(input logic [FW-1:0] nn);
      rst_n = 1'b0; pad = '0; ie = '1; n = nn; clr = '0; mask = '0;
      step(); step();
      rst_n = 1'b1;
   endtask

   typedef struct {
      logic          rst_n;
      logic [W-1:0]  pad;
      logic [W-1:0]  ie;
      logic [FW-1:0] n;
      logic [W-1:0]  exp_din;
      logic [W-1:0]  exp_rise;
      logic [W-1:0]  exp_fall;
   } vec_t;

   vec_t tbl [10];

   initial begin
      rst_n = 1'b0; pad = '0; ie = '0; n = '0; clr = '0; mask = '0;

      // Reset with pads high, release, rise after 3 cycles, then fall.
      tbl[0] = '{1'b0, 9'h1FF, 9'h1FF, 4'd0, 9'h000, 9'h000, 9'h000};
      tbl[1] = '{1'b0, 9'h1FF, 9'h1FF, 4'd0, 9'h000, 9'h000, 9'h000};
      tbl[2] = '{1'b1, 9'h1FF, 9'h1FF, 4'd0, 9'h000, 9'h000, 9'h000};
      tbl[3] = '{1'b1, 9'h1FF, 9'h1FF, 4'd0, 9'h000, 9'h000, 9'h000};
      tbl[4] = '{1'b1, 9'h1FF, 9'h1FF, 4'd0, 9'h1FF, 9'h1FF, 9'h000};
      tbl[5] = '{1'b1, 9'h1FF, 9'h1FF, 4'd0, 9'h1FF, 9'h000, 9'h000};
      tbl[6] = '{1'b1, 9'h000, 9'h1FF, 4'd0, 9'h1FF, 9'h000, 9'h000};
      tbl[7] = '{1'b1, 9'h000, 9'h1FF, 4'd0, 9'h1FF, 9'h000, 9'h000};
      tbl[8] = '{1'b1, 9'h000, 9'h1FF, 4'd0, 9'h000, 9'h000, 9'h1FF};
      tbl[9] = '{1'b1, 9'h000, 9'h1FF, 4'd0, 9'h000, 9'h000, 9'h000};

      for (int v = 0; v < 10; v++) begin
         rst_n = tbl[v].rst_n; pad = tbl[v].pad; ie = tbl[v].ie; n = tbl[v].n;
         step();
         chk("tbl_din",  32'(din_o),  32'(tbl[v].exp_din));
         chk("tbl_rise", 32'(rise_o), 32'(tbl[v].exp_rise));
         chk("tbl_fall", 32'(fall_o), 32'(tbl[v].exp_fall));
      end

      // Short pulse rejected, long pulse accepted after exactly 6 cycles (N=3).
      do_reset(4'd3);
      pad[0] = 1'b1;
      repeat (3) step();
      pad[0] = 1'b0;
      for (int k = 0; k < 8; k++) begin
         step();
         chk("glitch_din0",  32'(din_o[0]),  32'd0);
         chk("glitch_rise0", 32'(rise_o[0]), 32'd0);
      end
      pad[0] = 1'b1;
      repeat (5) step();
      chk("lat5_din0", 32'(din_o[0]), 32'd0);
      step();
      chk("lat6_din0",  32'(din_o[0]),  32'd1);
      chk("lat6_rise0", 32'(rise_o[0]), 32'd1);

      // Dropping ie forces a fall after 5 cycles (N=2).
      do_reset(4'd2);
      pad[4] = 1'b1;
      repeat (5) step();
      chk("ie_up_din4", 32'(din_o[4]), 32'd1);
      ie[4] = 1'b0;
      repeat (4) step();
      chk("ie_hold_din4", 32'(din_o[4]), 32'd1);
      step();
      chk("ie_drop_din4", 32'(din_o[4]), 32'd0);
      chk("ie_drop_fall4", 32'(fall_o[4]), 32'd1);

      // Threshold lowered below the running count.
      do_reset(4'd15);
      pad[2] = 1'b1;
      repeat (7) step();
      chk("thr_hold_din2", 32'(din_o[2]), 32'd0);
      n = 4'd2;
      step();
      chk("thr_din2",  32'(din_o[2]),  32'd1);
      chk("thr_rise2", 32'(rise_o[2]), 32'd1);
      step();
      chk("thr_rise2_off", 32'(rise_o[2]), 32'd0);

      // Event pending / irq on bit 8.
      do_reset(4'd0);
      mask = 9'h100;
      pad[8] = 1'b1;
      repeat (3) step();
      chk("evt_rise8", 32'(rise_o[8]), 32'd1);
      step();
`ifdef PADIN_EVT_IRQ_EN
      chk("evt_pend8", 32'(pend_o[8]), 32'd1);
      chk("evt_irq_early", 32'(irq_o), 32'd0);
      step();
      chk("evt_irq", 32'(irq_o), 32'd1);
`else
      chk("evt_pend_tied", 32'(pend_o), 32'd0);
      step();
      chk("evt_irq_tied", 32'(irq_o), 32'd0);
`endif
      pad[8] = 1'b0;
      repeat (3) step();
      chk("evt_fall8", 32'(fall_o[8]), 32'd1);
      clr[8] = 1'b1;
      step();
`ifdef PADIN_EVT_IRQ_EN
      chk("evt_setclr_pend8", 32'(pend_o[8]), 32'd1);
      step();
      chk("evt_clr_pend8", 32'(pend_o[8]), 32'd0);
      clr = '0;
      step();
      chk("evt_clr_irq", 32'(irq_o), 32'd0);
`else
      chk("evt_setclr_tied", 32'(pend_o), 32'd0);
      step();
      clr = '0;
      step();
      chk("evt_irq_tied2", 32'(irq_o), 32'd0);
`endif

      // Randomized traffic against the reference model.
      do_reset(4'($urandom_range(0, 4)));
      for (int c = 0; c < 2000; c++) begin
         pad = pad ^ (9'($urandom) & 9'($urandom) & 9'($urandom) & 9'($urandom));
         if ($urandom_range(0, 63) == 0) ie = ie ^ 9'($urandom);
         if ($urandom_range(0, 49) == 0) n = 4'($urandom_range(0, 5));
         if ($urandom_range(0, 99) == 0) mask = 9'($urandom);
         clr = ($urandom_range(0, 3) == 0) ? 9'($urandom) : 9'h000;
         rst_n = ($urandom_range(0, 499) != 0);
         step();
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
